mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sits between the pipeline memory stage and the byte-wide data memory.
- Accepts one load/store request per handshake and checks its alignment.
- Performs the access as a sequence of single-byte beats in big-endian order: byte at Address holds the most significant byte.
- Assembles load data with sign or zero extension and returns the result with a valid/ready response handshake.

Parameters:
- ADDR_BITS, 8, width of the byte address.
- DATA_W, 32, request/response data width; fixed at 32 for this revision.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_op  input  4  operation code: 0001 SW, 0010 SH, 0011 SB, 0100 LW, 0101 LH, 0110 LB, 0111 LHU, 1000 LBU.
- req_addr  input  ADDR_BITS  byte address.
- req_wdata  input  32  store data. SW uses [31:0], SH uses [15:0], SB uses [7:0].
- mem_addr  output  ADDR_BITS  byte address to memory.
- mem_we  output  1  byte write strobe.
- mem_wdata  output  8  byte to write.
- mem_rdata  input  8  byte read data; combinational from mem_addr, same cycle.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal op.

Behaviour:
- States: IDLE, BEAT, RESP.
- Reset (sync):
  - State goes to IDLE; beat counter 0.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
  - Reset mid-access abandons the access immediately; no further mem_we.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata, and set the beat count N: 4 for SW/LW, 2 for SH/LH/LHU, 1 for SB/LB/LBU.
  - Error check:
    - Word op with addr[1:0]!=0 is an error.
    - Half op with addr[0]!=0 is an error.
    - Op not in the list (0000, 1001-1111) is an error.
  - On error, go to RESP with resp_err=1; no memory beats occur.
  - Otherwise go to BEAT with beat index k=0.
- BEAT (one byte per cycle, k = 0..N-1):
  - mem_addr = latched addr + k, truncated to ADDR_BITS, so it wraps modulo 2^ADDR_BITS.
  - Stores:
    - mem_we=1 during each beat.
    - mem_wdata = byte (N-1-k) of the store field, counted from the LSB; the MSB goes first.
  - Loads:
    - mem_we=0.
    - mem_rdata is shifted into the assembly register each beat: acc = {acc[23:0], mem_rdata}.
  - After beat N-1, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable and held.
  - Extension of the assembled data:
    - LB: sign-extend bit 7.
    - LH: sign-extend bit 15.
    - LBU/LHU: zero-extend.
    - LW: unchanged.
  - Held until resp_ready=1. Then go to IDLE, with resp_valid=0 the next cycle.
  - resp_ready is ignored while resp_valid=0.
- Latency (resp_ready held high):
  - Response appears N+1 cycles after the accept edge; errors appear 1 cycle after.
  - Back-to-back throughput: one request per N+2 cycles.
- mem_we is never asserted outside BEAT. mem_addr may hold its last value when idle.
- req_ready=0 in BEAT and RESP; requests offered then are not accepted and must be held by the source.
- Simultaneous req_valid in the cycle RESP completes is not accepted until the following IDLE cycle.

Test Plan:
1. SW addr=0x04, wdata=0xDEADBEEF: 4 beats write DE,AD,BE,EF to 0x04..0x07, mem_we=1 for exactly 4 cycles. Then LW 0x04 returns resp_rdata=0xDEADBEEF, err=0, with resp_valid 5 cycles after accept.
2. SB 0x09 wdata=0x00000080, then LB 0x09 returns 0xFFFFFF80 and LBU 0x09 returns 0x00000080. SH 0x0A wdata=0x00008001, then LH 0x0A returns 0xFFFF8001 and LHU returns 0x00008001.
3. Misalignment: LW 0x02, SH 0x03 and op=1010 each give resp_err=1, rdata=0, resp_valid 1 cycle after accept. Zero mem_we cycles and memory contents unchanged.
4. Backpressure: hold resp_ready=0 for 5 cycles during an LW response. resp_valid/rdata stay stable and req_ready=0 throughout; a queued req_valid is accepted only after the release cycle.
5. Wrap: SW addr=0xFC with ADDR_BITS=8 writes 0xFC..0xFF. A wrap-case LHU at 0xFE reads 0xFE,0xFF, and mem_addr never exceeds 0xFF.
6. Reset asserted during beat 2 of an SW to 0x00: next cycle is IDLE with all outputs at reset values. Byte 0x03 is unwritten, and a following request completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Byte-serial load/store sequencer between the pipeline memory stage and a
// byte-wide data memory. One request is accepted per handshake, checked for
// alignment and legality, then performed as big-endian single-byte beats
// (the byte at the request address is the most significant). Loads are
// assembled, sign/zero extended and returned through a valid/ready response.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_op, req_addr, req_wdata operation code, byte address, store data
//   mem_addr, mem_we, mem_wdata byte memory address, write strobe, write byte
//   mem_rdata                   byte read data, combinational from mem_addr
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        extended load data (0 for stores/errors), error flag
module mem_access_sequencer #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err
);

  typedef enum logic [1:0] {StIdle, StBeat, StResp} state_e;

  localparam logic [3:0] OpSw  = 4'd1;
  localparam logic [3:0] OpSh  = 4'd2;
  localparam logic [3:0] OpSb  = 4'd3;
  localparam logic [3:0] OpLw  = 4'd4;
  localparam logic [3:0] OpLh  = 4'd5;
  localparam logic [3:0] OpLb  = 4'd6;
  localparam logic [3:0] OpLhu = 4'd7;
  localparam logic [3:0] OpLbu = 4'd8;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          data_q, data_d;  // store shift-out / load assembly
  logic [1:0]           k_q, k_d;        // current beat index
  logic [1:0]           last_q, last_d;  // index of the final beat (N-1)
  logic                 err_q, err_d;

  // Request decode
  logic       dec_legal, dec_word, dec_half, dec_store;
  logic [1:0] dec_last;
  logic [31:0] dec_wdata;
  logic       store_q;

  always_comb begin
    dec_legal = 1'b1;
    dec_word  = 1'b0;
    dec_half  = 1'b0;
    dec_store = 1'b0;
    dec_last  = 2'd0;
    case (req_op)
      OpSw, OpLw:         begin dec_word = 1'b1; dec_last = 2'd3; end
      OpSh, OpLh, OpLhu:  begin dec_half = 1'b1; dec_last = 2'd1; end
      OpSb, OpLb, OpLbu:  dec_last = 2'd0;
      default:            dec_legal = 1'b0;
    endcase
    dec_store = (req_op == OpSw) || (req_op == OpSh) || (req_op == OpSb);
    // Left-justify the store field so each beat simply emits the top byte.
    if (dec_word)      dec_wdata = req_wdata[31:0];
    else if (dec_half) dec_wdata = {req_wdata[15:0], 16'h0000};
    else               dec_wdata = {req_wdata[7:0], 24'h000000};
  end

  assign store_q = (op_q == OpSw) || (op_q == OpSh) || (op_q == OpSb);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    k_d        = k_q;
    last_d     = last_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d   = req_op;
          addr_d = req_addr;
          k_d    = 2'd0;
          last_d = dec_last;
          err_d  = !dec_legal || (dec_word && (req_addr[1:0] != 2'b00)) ||
                   (dec_half && req_addr[0]);
          data_d = dec_store ? dec_wdata : 32'h0;
          state_d = err_d ? StResp : StBeat;
        end
      end
      StBeat: begin
        mem_addr  = addr_q + ADDR_BITS'(k_q);
        mem_we    = store_q;
        mem_wdata = data_q[31:24];
        data_d    = {data_q[23:0], store_q ? 8'h00 : mem_rdata};
        k_d       = k_q + 2'd1;
        if (k_q == last_q) state_d = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q) begin
          case (op_q)
            OpLw:    resp_rdata = data_q;
            OpLh:    resp_rdata = {{16{data_q[15]}}, data_q[15:0]};
            OpLb:    resp_rdata = {{24{data_q[7]}}, data_q[7:0]};
            OpLhu:   resp_rdata = {16'h0000, data_q[15:0]};
            OpLbu:   resp_rdata = {24'h000000, data_q[7:0]};
            default: resp_rdata = '0;
          endcase
        end
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      k_q     <= 2'd0;
      last_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic       fill;
  int         we_cnt;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_BITS(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Byte memory: combinational read, write mid-cycle while the strobe is stable.
  assign mem_rdata = mem[mem_addr];

  always @(negedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h11;
      we_cnt <= 0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges from the request-drive point until resp_valid shows up.
  task automatic wait_resp(output int lat);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    assert (resp_valid === 1'b1)
    else begin
      errors++;
      $error("FAIL timeout: observed resp_valid=%b expected 1 within 40 cycles", resp_valid);
    end
  endtask

  task automatic do_req(input string tag, input logic [3:0] op, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int lat;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    wait_resp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, lat;
    rst = 1'b1; fill = 1'b1;
    req_valid = 1'b0; req_op = 4'd0; req_addr = 8'h00; req_wdata = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; fill = 1'b0;

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {mem_addr, mem_wdata, 5'd0, mem_we, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);

    // 1. SW / LW
    w0 = we_cnt;
    do_req("sw04", 4'b0001, 8'h04, 32'hDEADBEEF, 32'h0, 1'b0, 5);
    check("sw04_we_cycles", we_cnt - w0, 4);
    check("sw04_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
    do_req("lw04", 4'b0100, 8'h04, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // 2. Byte / half extension
    do_req("sb09", 4'b0011, 8'h09, 32'h00000080, 32'h0, 1'b0, 2);
    do_req("lb09", 4'b0110, 8'h09, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    do_req("lbu09", 4'b1000, 8'h09, 32'h0, 32'h00000080, 1'b0, 2);
    do_req("sh0a", 4'b0010, 8'h0A, 32'h00008001, 32'h0, 1'b0, 3);
    check("sh0a_mem", {16'h0, mem[8'h0A], mem[8'h0B]}, 32'h00008001);
    do_req("lh0a", 4'b0101, 8'h0A, 32'h0, 32'hFFFF8001, 1'b0, 3);
    do_req("lhu0a", 4'b0111, 8'h0A, 32'h0, 32'h00008001, 1'b0, 3);

    // 3. Misalignment and illegal op
    w0 = we_cnt;
    do_req("lw02", 4'b0100, 8'h02, 32'h0, 32'h0, 1'b1, 1);
    do_req("sh03", 4'b0010, 8'h03, 32'h0000ABCD, 32'h0, 1'b1, 1);
    do_req("op1010", 4'b1010, 8'h04, 32'h12345678, 32'h0, 1'b1, 1);
    check("err_we_cycles", we_cnt - w0, 0);
    check("err_mem", {mem[2], mem[3], mem[4], mem[5]}, 32'h1111DEAD);

    // 4. Backpressure with a queued request
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 4'b0100; req_addr = 8'h04; req_wdata = 32'h0;
    wait_resp(lat);
    check("bp_lat", lat, 5);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 8'h09;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {resp_valid, req_ready, 30'd0}, {2'b10, 30'd0});
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    check("bp_release_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("bp_idle", {30'd0, req_ready, resp_valid}, 32'd2);
    wait_resp(lat);
    check("bp_q_lat", lat, 2);
    check("bp_q_rdata", resp_rdata, 32'h00000080);
    @(posedge clk); #1;

    // 5. Top-of-memory addresses
    do_req("swfc", 4'b0001, 8'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 5);
    check("swfc_mem", {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 32'hCAFEF00D);
    check("swfc_no_spill", {24'h0, mem[8'h00]}, 32'h11);
    do_req("lhufe", 4'b0111, 8'hFE, 32'h0, 32'h0000F00D, 1'b0, 3);

    // 6. Reset during beat 2 of SW to 0x00
    req_valid = 1'b1; req_op = 4'b0001; req_addr = 8'h00; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rb_beat2", {23'd0, mem_we, mem_addr}, {23'd0, 1'b1, 8'h02});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rb_idle_ready", {31'd0, req_ready}, 32'd1);
    check("rb_idle_outs", {mem_addr, mem_wdata, 5'd0, mem_we, resp_valid, resp_err}, 32'd0);
    check("rb_idle_rdata", resp_rdata, 32'h0);
    repeat (3) @(posedge clk); #1;
    check("rb_mem", {mem[0], mem[1], mem[3]}, {8'h00, 24'h123411});
    do_req("rb_lw04", 4'b0100, 8'h04, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
